// File: rtl/four_bit_serial_transmitter_if.sv
// four_bit_serial_transmitter_if: parallel-load handshake and serial frame output bundle
// d/load_valid/load_ready: word handshake; tx_bit/tx_valid/tx_first/tx_last: serial stream
interface four_bit_serial_transmitter_if;
  logic [3:0] d;
  logic load_valid;
  logic load_ready;
  logic tx_bit;
  logic tx_valid;
  logic tx_first;
  logic tx_last;
  modport master (output d, load_valid, input load_ready, tx_bit, tx_valid, tx_first, tx_last);
  modport slave (input d, load_valid, output load_ready, tx_bit, tx_valid, tx_first, tx_last);
endinterface

// File: rtl/four_bit_serial_transmitter.sv
// four_bit_serial_transmitter: 4-bit parallel-in, LSB-first serial-out framer
// Ports: clk, reset (async active-high), bus (slave modport: d, load_valid, load_ready,
// tx_bit, tx_valid, tx_first, tx_last). Define SERIAL_TX_PARITY_EN for a 5th even-parity bit.
module four_bit_serial_transmitter (
  input logic clk,
  input logic reset,
  four_bit_serial_transmitter_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] LAST = 3'd4;
`else
  localparam logic [2:0] LAST = 3'd3;
`endif
  state_t state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [3:0] sh, sh_n;
  logic tx_valid_q, tx_first_q, tx_last_q;
  logic tx_valid_n, tx_first_n, tx_last_n;
  logic last, accept, fill;
  assign last = state == SHIFT && bit_cnt == LAST;
  assign bus.load_ready = state == IDLE || last;
  assign accept = bus.load_valid && bus.load_ready;
  assign bus.tx_bit = sh[0];
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_first = tx_first_q;
  assign bus.tx_last = tx_last_q;
`ifdef SERIAL_TX_PARITY_EN
  // parity enters the top on the first shift and reaches sh[0] exactly at bit_cnt 4
  assign fill = bit_cnt == 3'd0 ? ^sh : 1'b0;
`else
  assign fill = 1'b0;
`endif
  always_comb begin
    state_n = accept ? SHIFT : last ? IDLE : state;
    bit_cnt_n = accept || last ? 3'd0 : state == SHIFT ? bit_cnt + 3'd1 : bit_cnt;
    sh_n = accept ? bus.d : last ? 4'd0 : state == SHIFT ? {fill, sh[3:1]} : sh;
    tx_valid_n = accept || (state == SHIFT && !last);
    tx_first_n = accept;
    tx_last_n = !accept && state == SHIFT && bit_cnt == LAST - 3'd1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bit_cnt <= 3'd0;
      sh <= 4'd0;
      tx_valid_q <= 1'b0;
      tx_first_q <= 1'b0;
      tx_last_q <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      sh <= sh_n;
      tx_valid_q <= tx_valid_n;
      tx_first_q <= tx_first_n;
      tx_last_q <= tx_last_n;
    end
  end
endmodule

// File: doc/four_bit_serial_transmitter.md
FOUR_BIT_SERIAL_TRANSMITTER -- requirements
Module: four_bit_serial_transmitter

Interface
REQ-001 The module SHALL have no parameters; word width is fixed at 4 bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port d, input, 4 bits: the parallel word to transmit.
REQ-005 The module SHALL have port load_valid, input, 1 bit: d is valid this cycle.
REQ-006 The module SHALL have port load_ready, output, 1 bit: the word can be accepted this cycle.
REQ-007 The module SHALL have port tx_bit, output, 1 bit: the serial data bit, sent LSB first.
REQ-008 The module SHALL have port tx_valid, output, 1 bit: tx_bit carries frame data this cycle.
REQ-009 The module SHALL have port tx_first, output, 1 bit: tx_bit is the first bit of a frame.
REQ-010 The module SHALL have port tx_last, output, 1 bit: tx_bit is the last bit of a frame.

Function
REQ-011 The FSM SHALL have two states, IDLE and SHIFT, plus a 3-bit bit counter bit_cnt and a 4-bit shift register.
REQ-012 A word SHALL be accepted on a rising edge where load_valid=1 and load_ready=1; d is captured and the next state is SHIFT with bit_cnt=0.
REQ-013 load_ready SHALL be 1 in IDLE, and also 1 in SHIFT during the last-bit cycle (tx_last=1); it SHALL be 0 in all other cycles.
REQ-014 When load_valid=1 and load_ready=0, the module SHALL ignore d and leave its state unchanged; no stall or error is signalled.
REQ-015 Latency SHALL be one cycle: for a word accepted at edge N, d[0] appears on tx_bit in the cycle after edge N, then d[1], d[2] and d[3] on the following edges.
REQ-016 In SHIFT, tx_valid SHALL be 1; tx_first SHALL be 1 only when bit_cnt=0; the shift register shifts right by one bit per edge.
REQ-017 At the last-bit edge with an acceptance, the module SHALL load the new word and stay in SHIFT with bit_cnt=0, giving back-to-back frames with no gap.
REQ-018 At the last-bit edge without an acceptance, the module SHALL go to IDLE.
REQ-019 In IDLE, tx_valid, tx_first, tx_last and tx_bit SHALL all be 0.
REQ-020 All outputs except load_ready SHALL be driven directly from registers; load_ready is a function of state only and never of load_valid.
REQ-021 bit_cnt SHALL never exceed the last-bit index (3, or 4 with parity enabled); it is reset to 0 on every acceptance.

Reset
REQ-022 While reset=1, the module SHALL be in IDLE with bit_cnt=0, the shift register at 0, tx_bit=tx_valid=tx_first=tx_last=0 and load_ready=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately, without waiting for clk; no further bits of that word are sent after reset deasserts.
REQ-024 The first acceptance SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-025 With macro SERIAL_TX_PARITY_EN defined, each frame SHALL be 5 bits: d[0..3] followed by an even-parity bit (d[3]^d[2]^d[1]^d[0]).
  - tx_last is asserted on the parity bit.
  - The load_ready window of REQ-013 and the back-to-back rule of REQ-017 move to the parity cycle.
REQ-026 Without SERIAL_TX_PARITY_EN, each frame SHALL be exactly 4 bits, with tx_last on d[3]; no parity logic is present.

Verification
REQ-027 Single frame: reset, then d=4'b1011 with load_valid for one cycle -> tx_bit 1,1,0,1 on 4 consecutive cycles; tx_first on cycle 1, tx_last on cycle 4; back to IDLE.
REQ-028 Back-to-back: hold load_valid=1 with d=4'hA, then 4'h5 presented in the tx_last cycle -> 8 contiguous tx_valid cycles carrying 0,1,0,1,1,0,1,0.
REQ-029 Busy ignore: pulse load_valid with d=4'hF in cycle 2 of a frame of 4'h0 -> 4'hF is never transmitted, and output is 0,0,0,0 then idle.
REQ-030 Reset mid-frame: assert reset during bit 2 of 4'hC -> all outputs 0 asynchronously, load_ready=1, and no remaining bits after release.
REQ-031 Parity (SERIAL_TX_PARITY_EN defined): d=4'b0111 -> tx_bit 1,1,1,0,1, with tx_last on the 5th bit; d=4'b0011 -> parity bit 0.
REQ-032 Idle hold: 10 cycles with load_valid=0 after reset -> tx_valid=0, tx_bit=0 and load_ready=1 throughout.
